// File: rtl/bsg_cgol_pkg.sv
// Shared types and helpers for the Game-of-Life frame scheduler.
// Holds the scheduler state encoding plus width and frame-clamp helpers.
package bsg_cgol_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        UNLOAD = 2'd2
    } state_e;

    // Ceiling log2 that never returns zero, so one-entry ranges still get a bit.
    function automatic int safe_clog2(input int value);
        int result;
        result = $clog2(value);
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    function automatic int unsigned clamp_frames(input int unsigned frames,
                                                 input int unsigned max_frames);
        int unsigned result;
        result = (frames > max_frames) ? max_frames : frames;
        return result;
    endfunction

endpackage

// File: rtl/bsg_cgol_row_ctr.sv
// Row address counter shared by the load and unload phases.
// Wraps to zero after max_val_p and flags the final row through last_o.
module bsg_cgol_row_ctr
#(
    parameter int width_p   = 3,
    parameter int max_val_p = 7
)(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o,
    output logic               last_o
);

    logic [width_p-1:0] count_r;

    assign last_o  = (count_r == width_p'(max_val_p));
    assign count_o = count_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (clear_i) begin
            count_r <= '0;
        end else if (up_i) begin
            count_r <= last_o ? '0 : count_r + width_p'(1);
        end
    end

endmodule

// File: rtl/bsg_cgol_frame_sched.sv
// Frame scheduler: hands the cell array to load, run and unload phases in turn.
// It is the only driver of the array's write, step and read-address controls.
module bsg_cgol_frame_sched
    import bsg_cgol_pkg::*;
#(
    parameter  int board_width_p     = 8,
    parameter  int max_game_length_p = 255,
    localparam int row_addr_width_lp = safe_clog2(board_width_p),
    localparam int frame_width_lp    = safe_clog2(max_game_length_p + 1)
)(
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         en_i,

    input  logic [board_width_p-1:0]     data_i,
    input  logic [frame_width_lp-1:0]    frames_i,
    input  logic                         v_i,
    output logic                         ready_o,

    output logic [board_width_p-1:0]     data_o,
    output logic                         v_o,
    input  logic                         yumi_i,

    output logic [row_addr_width_lp-1:0] row_addr_o,
    output logic                         row_we_o,
    input  logic [board_width_p-1:0]     row_data_i,
    output logic                         en_o
);

    state_e                      state_r, state_n;
    logic [frame_width_lp-1:0]   gen_r, gen_n;
    logic                        out_of_reset_r;

    logic [row_addr_width_lp-1:0] row_cnt;
    logic                         row_last;
    logic                         row_up;
    logic                         row_clear;
    logic [frame_width_lp-1:0]    load_frames;

    assign load_frames = frame_width_lp'(clamp_frames(32'(frames_i),
                                                      32'(max_game_length_p)));

    bsg_cgol_row_ctr #(
        .width_p   (row_addr_width_lp),
        .max_val_p (board_width_p - 1)
    ) row_ctr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (row_clear),
        .up_i      (row_up),
        .count_o   (row_cnt),
        .last_o    (row_last)
    );

    assign row_addr_o = row_cnt;
    assign data_o     = row_data_i;

    // The out-of-reset flag keeps ready_o low until the first edge after reset releases.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r        <= LOAD;
            gen_r          <= '0;
            out_of_reset_r <= 1'b0;
        end else begin
            state_r        <= state_n;
            gen_r          <= gen_n;
            out_of_reset_r <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state_r;
        gen_n     = gen_r;
        ready_o   = 1'b0;
        v_o       = 1'b0;
        en_o      = 1'b0;
        row_we_o  = 1'b0;
        row_up    = 1'b0;
        row_clear = 1'b0;

        case (state_r)
            LOAD: begin
                ready_o = en_i & out_of_reset_r;
                if (v_i && ready_o) begin
                    row_we_o = 1'b1;
                    row_up   = 1'b1;
                    if (row_cnt == '0) begin
                        gen_n = load_frames;
                    end
                    // A zero-generation game skips straight to unloading the board as loaded.
                    if (row_last) begin
                        state_n = (gen_n == '0) ? UNLOAD : RUN;
                    end
                end
            end

            RUN: begin
                row_clear = 1'b1;
                if (en_i) begin
                    en_o  = 1'b1;
                    gen_n = gen_r - frame_width_lp'(1);
                    if (gen_r <= frame_width_lp'(1)) begin
                        state_n = UNLOAD;
                    end
                end
            end

            UNLOAD: begin
                v_o = en_i;
                if (v_o && yumi_i) begin
                    row_up = 1'b1;
                    if (row_last) begin
                        state_n = LOAD;
                    end
                end
            end

            default: begin
                state_n = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_bsg_cgol_frame_sched.sv
// Randomized self-checking bench for bsg_cgol_frame_sched with a 4x4 board.
// The modelled cell array adds one to every row per generation, so output rows encode the step count.
module tb_bsg_cgol_frame_sched;

    localparam int W    = 4;
    localparam int MAXG = 8;
    localparam int FW   = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          resetN;
    logic          enI;
    logic [W-1:0]  dataI;
    logic [FW-1:0] framesI;
    logic          vI;
    logic          readyO;
    logic [W-1:0]  dataO;
    logic          vO;
    logic          yumiI;
    logic [AW-1:0] rowAddrO;
    logic          rowWeO;
    logic [W-1:0]  rowDataI;
    logic          enO;

    logic [W-1:0]  cellMem [W];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_cgol_frame_sched #(
        .board_width_p     (W),
        .max_game_length_p (MAXG)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (resetN),
        .en_i       (enI),
        .data_i     (dataI),
        .frames_i   (framesI),
        .v_i        (vI),
        .ready_o    (readyO),
        .data_o     (dataO),
        .v_o        (vO),
        .yumi_i     (yumiI),
        .row_addr_o (rowAddrO),
        .row_we_o   (rowWeO),
        .row_data_i (rowDataI),
        .en_o       (enO)
    );

    // Behavioural cell array: row writes, and a whole-board "+1" per generation.
    assign rowDataI = cellMem[rowAddrO];

    always @(posedge clk) begin
        if (rowWeO) begin
            cellMem[rowAddrO] <= dataI;
        end else if (enO) begin
            for (int i = 0; i < W; i++) begin
                cellMem[i] <= cellMem[i] + 4'd1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (resetN) begin
            checkOutput("exclusive", 32'($countones({rowWeO, enO, vO}) <= 1), 32'(1));
        end
    end

    // Plays one full game: load (with gaps and enable drops), run, unload (with backpressure).
    task automatic applyStimulus(input logic [15:0] board, input int frames, input int gapPct,
                                 input int bpRow, input int bpLen, input int runGapAt,
                                 input bit randHold);
        int nEff;
        int hold;
        logic [W-1:0] expRow;
        nEff = (frames > MAXG) ? MAXG : frames;

        for (int r = 0; r < W; r++) begin
            while ($urandom_range(99) < gapPct) begin
                vI      = 1'b0;
                enI     = ($urandom_range(99) >= 25);
                yumiI   = 1'($urandom_range(1));
                dataI   = 4'($urandom);
                framesI = 4'($urandom);
                #1;
                checkOutput("load_idle_ready", 32'(readyO), 32'(enI));
                checkOutput("load_idle_we", 32'(rowWeO), 32'(0));
                checkOutput("load_idle_addr", 32'(rowAddrO), 32'(r));
                checkOutput("load_idle_vo", 32'(vO), 32'(0));
                @(negedge clk);
            end
            enI     = 1'b1;
            vI      = 1'b1;
            yumiI   = 1'($urandom_range(1));
            dataI   = board[r*W +: W];
            framesI = (r == 0) ? 4'(frames) : 4'($urandom);
            #1;
            checkOutput("load_ready", 32'(readyO), 32'(1));
            checkOutput("load_we", 32'(rowWeO), 32'(1));
            checkOutput("load_addr", 32'(rowAddrO), 32'(r));
            @(negedge clk);
        end
        vI = 1'b0;

        for (int k = 0; k < nEff; k++) begin
            if (k == runGapAt) begin
                for (int g = 0; g < 3; g++) begin
                    enI = 1'b0;
                    #1;
                    checkOutput("run_gap_en", 32'(enO), 32'(0));
                    checkOutput("run_gap_vo", 32'(vO), 32'(0));
                    @(negedge clk);
                end
                enI = 1'b1;
            end
            yumiI = 1'($urandom_range(1));
            #1;
            checkOutput("run_en", 32'(enO), 32'(1));
            checkOutput("run_ready", 32'(readyO), 32'(0));
            checkOutput("run_vo", 32'(vO), 32'(0));
            @(negedge clk);
        end

        for (int r = 0; r < W; r++) begin
            expRow = board[r*W +: W] + 4'(nEff);
            hold   = (r == bpRow) ? bpLen : (randHold ? int'($urandom_range(2)) : 0);
            for (int h = 0; h < hold; h++) begin
                yumiI = 1'b0;
                #1;
                checkOutput("unload_hold_vo", 32'(vO), 32'(1));
                checkOutput("unload_hold_addr", 32'(rowAddrO), 32'(r));
                checkOutput("unload_hold_data", 32'(dataO), 32'(expRow));
                @(negedge clk);
            end
            yumiI = 1'b1;
            #1;
            checkOutput("unload_vo", 32'(vO), 32'(1));
            checkOutput("unload_addr", 32'(rowAddrO), 32'(r));
            checkOutput("unload_data", 32'(dataO), 32'(expRow));
            @(negedge clk);
        end
        yumiI = 1'b0;
        #1;
        checkOutput("back_to_load_ready", 32'(readyO), 32'(1));
        checkOutput("back_to_load_vo", 32'(vO), 32'(0));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(readyO), 32'(0));
        checkOutput({tag, "_vo"}, 32'(vO), 32'(0));
        checkOutput({tag, "_en"}, 32'(enO), 32'(0));
        checkOutput({tag, "_we"}, 32'(rowWeO), 32'(0));
        checkOutput({tag, "_addr"}, 32'(rowAddrO), 32'(0));
    endtask

    initial begin
        resetN  = 1'b0;
        enI     = 1'b1;
        vI      = 1'b0;
        yumiI   = 1'b0;
        dataI   = '0;
        framesI = '0;
        #1;
        checkResetValues("reset");
        @(negedge clk);
        #2;
        resetN = 1'b1;
        #1;
        checkOutput("ready_before_edge", 32'(readyO), 32'(0));
        @(negedge clk);
        #1;
        checkOutput("ready_after_edge", 32'(readyO), 32'(1));

        // Basic game, zero frames, saturation, backpressure and enable gap.
        applyStimulus(16'h8421, 3, 0, -1, 0, -1, 1'b0);
        applyStimulus(16'h5a3c, 0, 0, -1, 0, -1, 1'b0);
        applyStimulus(16'h0f96, 15, 0, -1, 0, -1, 1'b0);
        applyStimulus(16'h1234, 2, 0, 2, 5, -1, 1'b0);
        applyStimulus(16'hc0de, 5, 0, -1, 0, 2, 1'b0);

        // Asynchronous reset after two load beats, applied between clock edges.
        for (int r = 0; r < 2; r++) begin
            enI     = 1'b1;
            vI      = 1'b1;
            dataI   = 4'($urandom);
            framesI = 4'd4;
            #1;
            checkOutput("prereset_addr", 32'(rowAddrO), 32'(r));
            @(negedge clk);
        end
        #2;
        resetN = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(negedge clk);
        #2;
        resetN = 1'b1;
        vI     = 1'b0;
        #1;
        checkOutput("rerelease_ready", 32'(readyO), 32'(0));
        @(negedge clk);
        #1;
        applyStimulus(16'h7e81, 4, 0, -1, 0, -1, 1'b0);

        for (int g = 0; g < 20; g++) begin
            int f;
            int nEff;
            f    = int'($urandom_range(15));
            nEff = (f > MAXG) ? MAXG : f;
            applyStimulus(16'($urandom), f, 30, int'($urandom_range(4)),
                          int'($urandom_range(1, 4)),
                          (nEff > 0 && $urandom_range(1) == 1) ? int'($urandom_range(nEff - 1)) : -1,
                          1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
